// File: rtl/bpi_pkg.sv
// Command opcodes, status-register bit positions and FSM/mode encodings for the BPI flash link,
// used by both the device-side responder and the host-side command sequencer.
package bpi_pkg;

  localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS = 8'h70;
  localparam logic [7:0] CMD_READ_ID     = 8'h90;
  localparam logic [7:0] CMD_CLR_STATUS  = 8'h50;
  localparam logic [7:0] CMD_PROG        = 8'h40;
  localparam logic [7:0] CMD_PROG_ALT    = 8'h10;
  localparam logic [7:0] CMD_ERASE       = 8'h20;
  localparam logic [7:0] CMD_CONFIRM     = 8'hD0;
  localparam logic [7:0] CMD_LOCK_SETUP  = 8'h60;
  localparam logic [7:0] CMD_LOCK        = 8'h01;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_LOCK_ERR  = 1;

  typedef enum logic [1:0] {
    MODE_ARRAY,
    MODE_STATUS,
    MODE_ID
  } mode_e;

  typedef enum logic [2:0] {
    ST_READY,
    ST_WAIT_DATA,
    ST_WAIT_CONF,
    ST_PROG_BUSY,
    ST_ERASE_SWEEP,
    ST_ERASE_TAIL
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_PROG_BUSY) || (s == ST_ERASE_SWEEP) || (s == ST_ERASE_TAIL);
  endfunction

endpackage

// File: rtl/bpi_resp_mem.sv
// Single-port 16-bit word RAM backing the emulated flash array; read-first, one-cycle read latency.
// Contents are never reset; no flow control.
module bpi_resp_mem #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/bpi_flash_responder.sv
// Flash-side BPI responder: strobe decode, P30 command subset, program/erase timing; block locking with BPI_RESP_LOCK_EN.
// Status/ID read data one cycle after address/mode, array data two; host polls BUSY/SR, writes during busy are dropped.
module bpi_flash_responder
  import bpi_pkg::*;
#(
  parameter int          MEM_AW      = 10,
  parameter int          BLK_AW      = 4,
  parameter int          PROG_CYCLES = 8,
  parameter int          ERASE_EXTRA = 4,
  parameter logic [15:0] DEV_ID      = 16'h8962
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        FCS_B,
  input  logic        FOE_B,
  input  logic        FWE_B,
  input  logic        FLATCH_B,
  input  logic [22:0] BPI_AD,
  input  logic [15:0] CFG_DAT_IN,
  output logic [15:0] CFG_DAT_OUT,
  output logic        CFG_DAT_OE,
  output logic        BUSY
);

  localparam logic [15:0] PROG_LOAD  = 16'(PROG_CYCLES - 1);
  localparam logic [15:0] ERASE_LOAD = 16'(ERASE_EXTRA - 1);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic              conf_lock_q;
  logic              flatch_b_q, fwe_b_q;
  logic [MEM_AW-1:0] addr_q, sweep_q;
  logic [7:0]        sr_q;
  logic [15:0]       timer_q;
  logic [15:0]       dout_q, dout_d;
  logic              oe_q;

  logic              latch_rise, wr_rise, sweep_end, blk_locked;
  logic [7:0]        cmd;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_wdata, mem_rdata;
  logic              unused_ad;

  assign latch_rise = ~flatch_b_q & FLATCH_B & ~FCS_B;
  assign wr_rise    = ~fwe_b_q & FWE_B & ~FCS_B & FOE_B;
  assign cmd        = CFG_DAT_IN[7:0];
  assign sweep_end  = &sweep_q[BLK_AW-1:0];
  assign unused_ad  = ^BPI_AD[22:MEM_AW];

`ifdef BPI_RESP_LOCK_EN
  logic [2**(MEM_AW-BLK_AW)-1:0] lock_q;
  logic [MEM_AW-BLK_AW-1:0]      blk;
  assign blk        = addr_q[MEM_AW-1:BLK_AW];
  assign blk_locked = lock_q[blk];
`else
  assign blk_locked = 1'b0;
`endif

  bpi_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) state_q <= ST_READY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY: begin
        if (wr_rise) begin
          case (cmd)
            CMD_PROG, CMD_PROG_ALT:     state_d = ST_WAIT_DATA;
            CMD_ERASE, CMD_LOCK_SETUP:  state_d = ST_WAIT_CONF;
            default:                    state_d = ST_READY;
          endcase
        end
      end
      ST_WAIT_DATA:   if (wr_rise) state_d = blk_locked ? ST_READY : ST_PROG_BUSY;
      ST_WAIT_CONF:   if (wr_rise) state_d = (!conf_lock_q && cmd == CMD_CONFIRM && !blk_locked)
                                             ? ST_ERASE_SWEEP : ST_READY;
      ST_PROG_BUSY:   if (timer_q == '0) state_d = ST_READY;
      ST_ERASE_SWEEP: if (sweep_end) state_d = (ERASE_EXTRA == 0) ? ST_READY : ST_ERASE_TAIL;
      ST_ERASE_TAIL:  if (timer_q == '0) state_d = ST_READY;
      default:        state_d = ST_READY;
    endcase
  end

  // Program is a read-modify-write against the RAM's registered read of addr_q: bits can only clear.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = mem_rdata & CFG_DAT_IN;
    if (state_q == ST_ERASE_SWEEP) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_q;
      mem_wdata = 16'hFFFF;
    end else if (state_q == ST_WAIT_DATA && wr_rise && !blk_locked) begin
      mem_we    = 1'b1;
    end

    dout_d = {8'h00, sr_q};
    if (!is_busy(state_q)) begin
      case (mode_q)
        MODE_ARRAY: dout_d = mem_rdata;
        MODE_ID:    dout_d = addr_q[0] ? DEV_ID : {14'h0022, blk_locked, 1'b1};
        default:    dout_d = {8'h00, sr_q};
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      flatch_b_q  <= 1'b1;
      fwe_b_q     <= 1'b1;
      addr_q      <= '0;
      mode_q      <= MODE_ARRAY;
      conf_lock_q <= 1'b0;
      sr_q        <= 8'h80;
      timer_q     <= '0;
      sweep_q     <= '0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
`ifdef BPI_RESP_LOCK_EN
      lock_q      <= '1;
`endif
    end else begin
      flatch_b_q <= FLATCH_B;
      fwe_b_q    <= FWE_B;
      oe_q       <= ~FCS_B & ~FOE_B;
      dout_q     <= dout_d;
      if (latch_rise) addr_q <= BPI_AD[MEM_AW-1:0];
      if (is_busy(state_q) && wr_rise && cmd == CMD_READ_STATUS) mode_q <= MODE_STATUS;

      case (state_q)
        ST_READY: begin
          if (wr_rise) begin
            case (cmd)
              CMD_READ_ARRAY:          mode_q <= MODE_ARRAY;
              CMD_READ_STATUS:         mode_q <= MODE_STATUS;
              CMD_READ_ID:             mode_q <= MODE_ID;
              CMD_CLR_STATUS:          sr_q[5:1] <= '0;
              CMD_PROG, CMD_PROG_ALT:  mode_q <= MODE_STATUS;
              CMD_ERASE: begin
                mode_q      <= MODE_STATUS;
                conf_lock_q <= 1'b0;
              end
              CMD_LOCK_SETUP: begin
                mode_q      <= MODE_STATUS;
                conf_lock_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WAIT_DATA: begin
          if (wr_rise) begin
            if (blk_locked) begin
              sr_q[SR_LOCK_ERR] <= 1'b1;
              sr_q[SR_PROG_ERR] <= 1'b1;
            end else begin
              sr_q[SR_READY] <= 1'b0;
              timer_q        <= PROG_LOAD;
            end
          end
        end
        ST_WAIT_CONF: begin
          if (wr_rise) begin
            if (conf_lock_q) begin
`ifdef BPI_RESP_LOCK_EN
              if (cmd == CMD_CONFIRM) lock_q[blk] <= 1'b0;
              else if (cmd == CMD_LOCK) lock_q[blk] <= 1'b1;
              else begin
                sr_q[SR_ERASE_ERR] <= 1'b1;
                sr_q[SR_PROG_ERR]  <= 1'b1;
              end
`endif
            end else if (cmd == CMD_CONFIRM) begin
              if (blk_locked) begin
                sr_q[SR_LOCK_ERR]  <= 1'b1;
                sr_q[SR_ERASE_ERR] <= 1'b1;
              end else begin
                sweep_q        <= {addr_q[MEM_AW-1:BLK_AW], {BLK_AW{1'b0}}};
                sr_q[SR_READY] <= 1'b0;
              end
            end else begin
              sr_q[SR_ERASE_ERR] <= 1'b1;
              sr_q[SR_PROG_ERR]  <= 1'b1;
            end
          end
        end
        ST_ERASE_SWEEP: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_end) begin
            if (ERASE_EXTRA == 0) sr_q[SR_READY] <= 1'b1;
            else                  timer_q <= ERASE_LOAD;
          end
        end
        ST_PROG_BUSY, ST_ERASE_TAIL: begin
          if (timer_q == '0) sr_q[SR_READY] <= 1'b1;
          else               timer_q <= timer_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign CFG_DAT_OUT = dout_q;
  assign CFG_DAT_OE  = oe_q;
  assign BUSY        = ~sr_q[SR_READY];

endmodule

// File: tb/tb_bpi_flash_responder.sv
// Directed bench for bpi_flash_responder: host-side strobe sequences with hand-computed responses.
module tb_bpi_flash_responder;

  logic        CLK, RST_B, FCS_B, FOE_B, FWE_B, FLATCH_B;
  logic [22:0] BPI_AD;
  logic [15:0] CFG_DAT_IN, CFG_DAT_OUT;
  logic        CFG_DAT_OE, BUSY;

  int n_pass  = 0;
  int n_total = 0;
  int nb;
  logic [15:0] rd;

  bpi_flash_responder dut (
    .CLK         (CLK),
    .RST_B       (RST_B),
    .FCS_B       (FCS_B),
    .FOE_B       (FOE_B),
    .FWE_B       (FWE_B),
    .FLATCH_B    (FLATCH_B),
    .BPI_AD      (BPI_AD),
    .CFG_DAT_IN  (CFG_DAT_IN),
    .CFG_DAT_OUT (CFG_DAT_OUT),
    .CFG_DAT_OE  (CFG_DAT_OE),
    .BUSY        (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_latch(input logic [22:0] a);
    BPI_AD   = a;
    FLATCH_B = 1'b0;
    tick(1);
    FLATCH_B = 1'b1;
    tick(1);
  endtask

  task automatic bus_write(input logic [15:0] d);
    CFG_DAT_IN = d;
    FWE_B      = 1'b0;
    tick(1);
    FWE_B      = 1'b1;
    tick(1);
  endtask

  task automatic bus_read(output logic [15:0] d);
    FOE_B = 1'b0;
    tick(3);
    d     = CFG_DAT_OUT;
    FOE_B = 1'b1;
    tick(1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    RST_B = 1'b0; FCS_B = 1'b1; FOE_B = 1'b1; FWE_B = 1'b1; FLATCH_B = 1'b1;
    BPI_AD = '0; CFG_DAT_IN = '0;
    tick(2);
    chk("rst_dout", CFG_DAT_OUT, 16'h0000);
    chk("rst_oe", 16'(CFG_DAT_OE), 16'h0000);
    chk("rst_busy", 16'(BUSY), 16'h0000);
    RST_B = 1'b1;
    tick(2);
    FCS_B = 1'b0;
    tick(1);

    // output-enable timing
    bus_latch(23'h000010);
    FOE_B = 1'b0;
    chk("oe_pre", 16'(CFG_DAT_OE), 16'h0000);
    tick(1);
    chk("oe_1cyc", 16'(CFG_DAT_OE), 16'h0001);
    FOE_B = 1'b1;
    tick(1);
    chk("oe_drop", 16'(CFG_DAT_OE), 16'h0000);
    bus_write(16'h0070);
    bus_read(rd);
    chk("sr_reset", rd, 16'h0080);

`ifdef BPI_RESP_LOCK_EN
    bus_write(16'h0040);
    bus_write(16'h0000);
    count_busy(nb);
    chk("lk_first_nobusy", 16'(nb), 16'd0);
    bus_read(rd);
    chk("lk_first_sr", rd, 16'h0092);
    bus_write(16'h0050);
    bus_write(16'h0060);
    bus_write(16'h00D0);
    bus_latch(23'h000020);
    bus_write(16'h0060);
    bus_write(16'h00D0);
`endif

    // known pattern in block 2 to prove a later block-1 erase leaves it alone
    bus_latch(23'h000020);
    bus_write(16'h0020);
    bus_write(16'h00D0);
    count_busy(nb);
    chk("erase_busy_blk2", 16'(nb), 16'd20);
    bus_write(16'h0040);
    bus_write(16'hA5C3);
    count_busy(nb);
    chk("prog_busy_020", 16'(nb), 16'd8);
    bus_read(rd);
    chk("sr_after_prog", rd, 16'h0080);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("rd_020", rd, 16'hA5C3);

    bus_latch(23'h000013);
    bus_write(16'h0020);
    bus_write(16'h00D0);
    count_busy(nb);
    chk("erase_busy_blk1", 16'(nb), 16'd20);
    bus_write(16'h00FF);
    bus_latch(23'h000010);
    bus_read(rd);
    chk("erased_010", rd, 16'hFFFF);
    bus_latch(23'h00001F);
    bus_read(rd);
    chk("erased_01F", rd, 16'hFFFF);
    bus_latch(23'h000020);
    bus_read(rd);
    chk("kept_020", rd, 16'hA5C3);

    bus_latch(23'h7FFC10);
    bus_write(16'h0040);
    bus_write(16'h1234);
    count_busy(nb);
    chk("prog_busy_010", 16'(nb), 16'd8);
    bus_read(rd);
    chk("sr_prog_010", rd, 16'h0080);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("rd_1234", rd, 16'h1234);
    bus_write(16'h0040);
    bus_write(16'hFF00);
    count_busy(nb);
    chk("prog2_busy", 16'(nb), 16'd8);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("rd_and_1200", rd, 16'h1200);

    bus_write(16'h0020);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("sr_seq_err", rd, 16'h00B0);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("rd_with_err", rd, 16'h1200);
    bus_write(16'h0050);
    bus_write(16'h0070);
    bus_read(rd);
    chk("sr_cleared", rd, 16'h0080);

    bus_write(16'h0090);
    bus_latch(23'h000000);
    bus_read(rd);
`ifdef BPI_RESP_LOCK_EN
    chk("id_mfr", rd, 16'h008B);
`else
    chk("id_mfr", rd, 16'h0089);
`endif
    bus_latch(23'h000001);
    bus_read(rd);
    chk("id_dev", rd, 16'h8962);

    bus_latch(23'h000011);
    bus_write(16'h0010);
    bus_write(16'h0F0F);
    count_busy(nb);
    chk("prog_alt_busy", 16'(nb), 16'd8);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("rd_alt", rd, 16'h0F0F);

`ifdef BPI_RESP_LOCK_EN
    bus_latch(23'h000010);
    bus_write(16'h0060);
    bus_write(16'h0001);
    bus_write(16'h0040);
    bus_write(16'h0000);
    count_busy(nb);
    chk("lk_nobusy", 16'(nb), 16'd0);
    bus_read(rd);
    chk("lk_sr", rd, 16'h0092);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("lk_unchanged", rd, 16'h1200);
    bus_write(16'h0090);
    bus_read(rd);
    chk("lk_id_bit", rd, 16'h008B);
    bus_write(16'h0050);
    bus_write(16'h0060);
    bus_write(16'h0055);
    bus_read(rd);
    chk("lk_bad_conf", rd, 16'h00B0);
    bus_write(16'h0050);
    bus_write(16'h0060);
    bus_write(16'h00D0);
    bus_write(16'h0040);
    bus_write(16'h0000);
    count_busy(nb);
    chk("unlk_busy", 16'(nb), 16'd8);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("unlk_prog", rd, 16'h0000);
`else
    bus_write(16'h0060);
    bus_write(16'h00FF);
    bus_read(rd);
    chk("nolock_consumed", rd, 16'h0080);
`endif

    // abort an erase partway: swept words stay erased, the rest keep their data
    bus_latch(23'h00001F);
    bus_write(16'h0040);
    bus_write(16'h0000);
    count_busy(nb);
    chk("prog_01F_busy", 16'(nb), 16'd8);
    bus_latch(23'h000013);
    bus_write(16'h0020);
    bus_write(16'h00D0);
    tick(5);
    chk("busy_mid_erase", 16'(BUSY), 16'h0001);
    #1;
    RST_B = 1'b0;
    #1;
    chk("abort_busy", 16'(BUSY), 16'h0000);
    chk("abort_dout", CFG_DAT_OUT, 16'h0000);
    #1;
    RST_B = 1'b1;
    tick(2);
    bus_latch(23'h000010);
    bus_read(rd);
    chk("abort_swept", rd, 16'hFFFF);
    bus_latch(23'h00001F);
    bus_read(rd);
    chk("abort_kept", rd, 16'h0000);
    bus_write(16'h0070);
    bus_read(rd);
    chk("abort_sr", rd, 16'h0080);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
